// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, reads a 1-cycle-latency instruction ROM,
// and buffers returned {instr, pc} pairs in a small FIFO feeding decode via valid/ready.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_re,
    output logic [31:0] imem_a,
    input  logic [31:0] imem_rd,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
);

    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned CW  = $clog2(DEPTH + 1);
    localparam int unsigned CXW = CW + 1;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    logic [31:0]  pc;
    logic [31:0]  inflight_pc;
    logic         inflight;
    logic [CW-1:0] count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    fetch_entry_t mem [DEPTH];
    fetch_entry_t head;

    logic          pop;
    logic          push;
    logic          issue;
    logic [CXW-1:0] credit;
    logic          unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Credits: buffered + in-flight entries after this cycle's pop must leave room.
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    assign push      = inflight & ~redirect_valid;
    assign credit    = {1'b0, count} + CXW'(inflight) - CXW'(pop);
    assign issue     = ~rst & ~redirect_valid & (credit < CXW'(DEPTH));

    assign imem_re = issue;
    assign imem_a  = pc;

    // PC and outstanding-read tracking; redirect wins over issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect_valid) begin
            pc       <= {redirect_pc[31:2], 2'b00};
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= pc;
                pc          <= pc + 32'd4;
            end
        end
    end

    // FIFO occupancy and pointers; a redirect empties the buffer outright.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (redirect_valid) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is intentionally left unreset; only occupancy decides validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{instr: imem_rd, pc: inflight_pc};
        end
    end

    assign head      = mem[rd_ptr];
    assign out_instr = out_valid ? head.instr : 32'h0;
    assign out_pc    = out_valid ? head.pc    : 32'h0;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: ROM word at byte address a is 0x100 + a/4.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_re;
    logic [31:0] imem_a;
    logic [31:0] imem_rd = 32'h0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    int n_checks = 0;
    int n_errors = 0;

    instr_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_re        (imem_re),
        .imem_a         (imem_a),
        .imem_rd        (imem_rd),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'h100 + {2'b00, a[31:2]};
    endfunction

    // ROM with 1-cycle synchronous read, holding data when not enabled
    always @(posedge clk) begin
        if (imem_re) imem_rd <= rom_word(imem_a);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc, input logic [31:0] instr);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_pc"}, out_pc, pc);
        check({tag, "_instr"}, out_instr, instr);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;

        // reset state and start-up latency
        tick(); tick();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_re", 32'(imem_re), 32'd0);
        check("rst_a", imem_a, 32'h0);
        check("rst_instr", out_instr, 32'h0);
        check("rst_pc", out_pc, 32'h0);
        rst = 1'b0;
        tick();
        check("lat_valid", 32'(out_valid), 32'd0);
        check("lat_a", imem_a, 32'h4);
        tick(); check_head("s0", 32'h0, 32'h100);
        tick(); check_head("s1", 32'h4, 32'h101);
        tick(); check_head("s2", 32'h8, 32'h102);

        // back-pressure from start
        rst = 1'b1; out_ready = 1'b0;
        tick();
        rst = 1'b0;
        repeat (6) tick();
        check_head("bp_hold", 32'h0, 32'h100);
        check("bp_re", 32'(imem_re), 32'd0);
        check("bp_a", imem_a, 32'h8);
        out_ready = 1'b1;
        #1 check("bp_re_rel", 32'(imem_re), 32'd1);
        tick(); check_head("bp1", 32'h4, 32'h101);
        tick(); check_head("bp2", 32'h8, 32'h102);
        tick(); check_head("bp3", 32'hC, 32'h103);

        // redirect with buffered entry and read in flight, downstream stalled
        out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h43;
        #1 check("rd_re", 32'(imem_re), 32'd0);
        tick();
        redirect_valid = 1'b0; out_ready = 1'b1;
        check("rd_valid0", 32'(out_valid), 32'd0);
        check("rd_pc0", out_pc, 32'h0);
        check("rd_instr0", out_instr, 32'h0);
        check("rd_a", imem_a, 32'h40);
        tick(); check("rd_valid1", 32'(out_valid), 32'd0);
        tick(); check_head("rd_h0", 32'h40, 32'h110);
        tick(); check_head("rd_h1", 32'h44, 32'h111);

        // redirect coinciding with a pop and a response, then PC wrap
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        check("rp_valid0", 32'(out_valid), 32'd0);
        check("rp_instr0", out_instr, 32'h0);
        check("rp_a", imem_a, 32'hFFFF_FFF8);
        tick(); check("rp_valid1", 32'(out_valid), 32'd0);
        tick(); check_head("wr0", 32'hFFFF_FFF8, 32'h4000_00FE);
        tick(); check_head("wr1", 32'hFFFF_FFFC, 32'h4000_00FF);
        tick(); check_head("wr2", 32'h0000_0000, 32'h100);

        // asynchronous reset between edges
        #2 rst = 1'b1;
        #1;
        check("ar_valid", 32'(out_valid), 32'd0);
        check("ar_re", 32'(imem_re), 32'd0);
        check("ar_a", imem_a, 32'h0);
        check("ar_pc", out_pc, 32'h0);
        tick();
        rst = 1'b0;
        tick(); check("ar_lat", 32'(out_valid), 32'd0);
        tick(); check_head("ar_h0", 32'h0, 32'h100);
        tick(); check_head("ar_h1", 32'h4, 32'h101);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
